led_alarm_ctrl: RTL and testbench

LED_ALARM_CTRL -- requirements
Module: led_alarm_ctrl

---
 rtl/led_pkg.sv | 11 +
 rtl/key_debounce.sv | 36 +++
 rtl/led_alarm_ctrl.sv | 55 +++++
 tb/tb_led_alarm_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared FSM state encoding and default timing values for the LED alarm controller.
package led_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ALARM   = 2'd1,
      LOCKOUT = 2'd2
   } state_t;
   localparam int DEBOUNCE_CYC_DEF = 1_000_000;
   localparam int ALARM_CYC_DEF    = 500_000_000;
   localparam int LOCK_CYC_DEF     = 50_000_000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a bouncing active-low key and emits one pulse per accepted press.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_n,
   output logic key_press
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   logic [1:0]    sync;
   logic          stable;
   logic          stable_q;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync      <= 2'b11;
         stable    <= 1'b1;
         stable_q  <= 1'b1;
         cnt       <= '0;
         key_press <= 1'b0;
      end else begin
         sync      <= {sync[0], key_n};
         stable_q  <= stable;
         key_press <= stable_q & ~stable;
         // a level is accepted only after it has differed from stable for DEBOUNCE_CYC cycles
         if (sync[1] == stable)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            stable <= sync[1];
            cnt    <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/led_alarm_ctrl.sv
// led_alarm_ctrl: alarm FSM driven by fault and a debounced key, with timed auto-clear and
// acknowledge lockout; outputs are registered from next-state so they move with state.
module led_alarm_ctrl
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int ALARM_CYC    = ALARM_CYC_DEF,
   parameter int LOCK_CYC     = LOCK_CYC_DEF
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       key_n,
   input  logic       fault,
   output logic       blink_hold,
   output logic       alarm_active,
   output logic       key_press,
   output logic [1:0] state
);
   localparam int TMAX = (ALARM_CYC > LOCK_CYC) ? ALARM_CYC : LOCK_CYC;
   localparam int TW   = $clog2(TMAX);
   state_t        cur;
   state_t        nxt;
   logic [TW-1:0] timer;
   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk       (clk),
      .rstn      (rstn),
      .key_n     (key_n),
      .key_press (key_press)
   );
   assign state = cur;
   always_comb begin
      nxt = IDLE;
      case (cur)
         IDLE:    nxt = (fault || key_press) ? ALARM : IDLE;
         // acknowledge wins over a simultaneous timeout
         ALARM:   nxt = key_press ? LOCKOUT : (timer == TW'(ALARM_CYC - 1)) ? IDLE : ALARM;
         LOCKOUT: nxt = (timer == TW'(LOCK_CYC - 1)) ? IDLE : LOCKOUT;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cur          <= IDLE;
         timer        <= '0;
         blink_hold   <= 1'b1;
         alarm_active <= 1'b0;
      end else begin
         cur          <= nxt;
         // held at zero in IDLE so the counter can never wrap
         timer        <= (nxt != cur || nxt == IDLE) ? '0 : timer + 1'b1;
         blink_hold   <= (nxt != ALARM);
         alarm_active <= (nxt == ALARM);
      end
   end
endmodule

// File: tb/tb_led_alarm_ctrl.sv
// tb_led_alarm_ctrl: directed scenarios for led_alarm_ctrl with small timing parameters.
module tb_led_alarm_ctrl;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       key_n = 1'b1;
   logic       fault = 1'b0;
   logic       blink_hold;
   logic       alarm_active;
   logic       key_press;
   logic [1:0] state;
   int         errors = 0;
   int         checks = 0;

   led_alarm_ctrl #(.DEBOUNCE_CYC(4), .ALARM_CYC(20), .LOCK_CYC(8)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .key_n        (key_n),
      .fault        (fault),
      .blink_hold   (blink_hold),
      .alarm_active (alarm_active),
      .key_press    (key_press),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      key_n = 1'b1;
      fault = 1'b0;
      rstn  = 1'b0;
      #3;
      rstn  = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      tick();
      fault = 1'b1;
      tick();
      checks++;
      if (state !== 2'd1 || blink_hold !== 1'b0) begin
         errors++;
         $display("FAIL reset_pre_alarm state=%0d blink_hold=%0b required state=1 blink_hold=0", state, blink_hold);
      end
      #3;
      rstn = 1'b0;
      #1;
      checks++;
      if (state !== 2'd0 || blink_hold !== 1'b1 || alarm_active !== 1'b0 || key_press !== 1'b0) begin
         errors++;
         $display("FAIL reset_async state=%0d blink_hold=%0b alarm_active=%0b key_press=%0b required 0/1/0/0",
                  state, blink_hold, alarm_active, key_press);
      end
      tick();
      checks++;
      if (state !== 2'd0 || blink_hold !== 1'b1) begin
         errors++;
         $display("FAIL reset_held state=%0d blink_hold=%0b required state=0 blink_hold=1", state, blink_hold);
      end
      fault = 1'b0;
      #3;
      rstn = 1'b1;
      tick();
      checks++;
      if (state !== 2'd0 || blink_hold !== 1'b1) begin
         errors++;
         $display("FAIL reset_release state=%0d blink_hold=%0b required state=0 blink_hold=1", state, blink_hold);
      end
   endtask

   task automatic test_debounce();
      int pulses = 0;
      apply_reset();
      // edge 1 samples the first low; 2 sync + 4 debounce edges, pulse registered after edge 7
      key_n = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         pulses += int'(key_press);
         checks++;
         if (key_press !== (k == 7)) begin
            errors++;
            $display("FAIL press_pulse edge=%0d key_press=%0b required %0b", k, key_press, (k == 7));
         end
      end
      checks++;
      if (pulses != 1 || state !== 2'd1) begin
         errors++;
         $display("FAIL press_count pulses=%0d state=%0d required pulses=1 state=1", pulses, state);
      end
      key_n = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         pulses += int'(key_press);
      end
      checks++;
      if (pulses != 0 || state !== 2'd1) begin
         errors++;
         $display("FAIL release_no_pulse pulses=%0d state=%0d required pulses=0 state=1", pulses, state);
      end
      apply_reset();
      key_n = 1'b0;
      repeat (3) tick();
      key_n = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         pulses += int'(key_press);
      end
      checks++;
      if (pulses != 0 || state !== 2'd0) begin
         errors++;
         $display("FAIL glitch_reject pulses=%0d state=%0d required pulses=0 state=0", pulses, state);
      end
   endtask

   task automatic test_alarm_timeout();
      apply_reset();
      fault = 1'b1;
      tick();
      fault = 1'b0;
      checks++;
      if (state !== 2'd1 || blink_hold !== 1'b0 || alarm_active !== 1'b1) begin
         errors++;
         $display("FAIL alarm_enter state=%0d blink_hold=%0b alarm_active=%0b required 1/0/1", state, blink_hold, alarm_active);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (state !== ((k < 20) ? 2'd1 : 2'd0) || blink_hold !== (k == 20)) begin
            errors++;
            $display("FAIL alarm_timeout k=%0d state=%0d blink_hold=%0b required state=%0d blink_hold=%0b",
                     k, state, blink_hold, (k < 20) ? 1 : 0, (k == 20));
         end
      end
   endtask

   task automatic test_ack_at_timeout();
      apply_reset();
      fault = 1'b1;
      tick();
      fault = 1'b0;
      repeat (12) tick();
      // first low sampled at edge 13 -> key_press visible after edge 19, while timer=19
      key_n = 1'b0;
      repeat (7) tick();
      checks++;
      if (key_press !== 1'b1 || state !== 2'd1) begin
         errors++;
         $display("FAIL ack_align key_press=%0b state=%0d required key_press=1 state=1", key_press, state);
      end
      tick();
      checks++;
      if (state !== 2'd2 || blink_hold !== 1'b1 || alarm_active !== 1'b0) begin
         errors++;
         $display("FAIL ack_wins state=%0d blink_hold=%0b alarm_active=%0b required 2/1/0", state, blink_hold, alarm_active);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (state !== ((k < 8) ? 2'd2 : 2'd0)) begin
            errors++;
            $display("FAIL lockout_exit k=%0d state=%0d required %0d", k, state, (k < 8) ? 2 : 0);
         end
      end
      key_n = 1'b1;
   endtask

   task automatic test_lockout_fault();
      int guard = 0;
      apply_reset();
      fault = 1'b1;
      tick();
      key_n = 1'b0;
      while (state !== 2'd2 && guard < 20) begin
         tick();
         guard++;
      end
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL lockout_reach state=%0d required 2 within 20 cycles", state);
      end
      key_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (state !== ((k < 8) ? 2'd2 : (k == 8) ? 2'd0 : 2'd1) || blink_hold !== (k < 9)) begin
            errors++;
            $display("FAIL lockout_refault k=%0d state=%0d blink_hold=%0b required state=%0d blink_hold=%0b",
                     k, state, blink_hold, (k < 8) ? 2 : (k == 8) ? 0 : 1, (k < 9));
         end
      end
      fault = 1'b0;
   endtask

   task automatic test_key_ack();
      apply_reset();
      key_n = 1'b0;
      repeat (10) tick();
      checks++;
      if (state !== 2'd1 || blink_hold !== 1'b0) begin
         errors++;
         $display("FAIL key_alarm state=%0d blink_hold=%0b required state=1 blink_hold=0", state, blink_hold);
      end
      key_n = 1'b1;
      repeat (8) tick();
      key_n = 1'b0;
      repeat (8) tick();
      checks++;
      if (state !== 2'd2 || blink_hold !== 1'b1 || alarm_active !== 1'b0) begin
         errors++;
         $display("FAIL key_ack state=%0d blink_hold=%0b alarm_active=%0b required 2/1/0", state, blink_hold, alarm_active);
      end
      key_n = 1'b1;
   endtask

   initial begin
      repeat (2) tick();
      test_reset();
      test_debounce();
      test_alarm_timeout();
      test_ack_at_timeout();
      test_lockout_fault();
      test_key_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
